dispatch_scheduler: RTL and testbench

Decode-to-dispatch controller for the out-of-order core. It accepts one fetched instruction per cycle over a valid/ready handshake and holds it in a single-entry dispatch register. It classifies the instruction by functional unit and steers it to the ALU, branch or load/store reservation station. Dispatch fires only when the target station, the ROB and, where a destination is written, the physical-register free list can all accept it; illegal opcodes and pipeline flushes are handled here.

---
 rtl/dispatch_scheduler_if.sv | 38 +++
 rtl/dispatch_scheduler.sv | 110 +++++++++++
 tb/tb_dispatch_scheduler.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_scheduler_if.sv
// Fetch-to-dispatch bundle: fetch handshake, flush, resource readies and dispatch outputs.
// Latency: none; this is wiring only.
// Backpressure: fetch is held off through in_ready; dispatch waits on rs_ready, rob_ready and fl_valid.
interface dispatch_scheduler_if #(
  parameter int XLEN    = 32,
  parameter int STALL_W = 16
);
  logic               in_valid;
  logic [XLEN-1:0]    in_instr;
  logic [XLEN-1:0]    in_pc;
  logic               in_ready;
  logic               flush;
  logic [2:0]         rs_ready;
  logic               rob_ready;
  logic               fl_valid;
  logic [2:0]         disp_valid;
  logic [XLEN-1:0]    disp_instr;
  logic [XLEN-1:0]    disp_pc;
  logic               rob_alloc;
  logic               fl_pop;
  logic               illegal;
  logic [31:0]        disp_cnt;
  logic [STALL_W-1:0] stall_cnt;

  // Fetch/backend side: drives instructions and resource readies.
  modport master (
    output in_valid, in_instr, in_pc, flush, rs_ready, rob_ready, fl_valid,
    input  in_ready, disp_valid, disp_instr, disp_pc, rob_alloc, fl_pop,
           illegal, disp_cnt, stall_cnt
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_instr, in_pc, flush, rs_ready, rob_ready, fl_valid,
    output in_ready, disp_valid, disp_instr, disp_pc, rob_alloc, fl_pop,
           illegal, disp_cnt, stall_cnt
  );
endinterface

// File: rtl/dispatch_scheduler.sv
// Single-entry decode-to-dispatch register steering instructions to ALU/branch/LSU stations.
// Latency: capture at edge N, earliest dispatch request in cycle N+1; capture and fire may overlap.
// Backpressure: in_ready drops while an instruction is held and cannot fire, or while flushing.
module dispatch_scheduler #(
  parameter int XLEN    = 32,
  parameter int STALL_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  dispatch_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HOLD, EXC} state_t;

  state_t             state;
  logic [XLEN-1:0]    instr_q;
  logic [XLEN-1:0]    pc_q;
  logic               illegal_q;
  logic [31:0]        disp_cnt_q;
  logic [STALL_W-1:0] stall_q;

  logic [2:0]         unit;
  logic               need_preg;
  logic               go;
  logic [2:0]         disp_valid;
  logic               fire;
  logic               in_ready;
  logic               capture;

  // One-hot functional unit in rs_ready bit order; zero means unsupported opcode.
  function automatic logic [2:0] fu_class(input logic [6:0] opc);
    case (opc)
      7'b0010011, 7'b0110111, 7'b0110011: fu_class = 3'b001;
      7'b1100011, 7'b1100111:             fu_class = 3'b010;
      7'b0000011, 7'b0100011:             fu_class = 3'b100;
      default:                            fu_class = 3'b000;
    endcase
  endfunction

  // Opcodes that write rd consume a physical register unless rd is x0.
  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      7'b0010011, 7'b0110111, 7'b0110011, 7'b0000011, 7'b1100111: writes_rd = 1'b1;
      default:                                                    writes_rd = 1'b0;
    endcase
  endfunction

  // Dispatch handshake, combinational from state and the ready inputs; flush suppresses everything.
  always_comb begin
    unit       = fu_class(instr_q[6:0]);
    need_preg  = writes_rd(instr_q[6:0]) && (instr_q[11:7] != 5'd0);
    go         = bus.rob_ready && (!need_preg || bus.fl_valid);
    disp_valid = 3'b000;
    if (state == HOLD && go && !bus.flush) begin
      disp_valid = unit;
    end
    fire     = |(disp_valid & bus.rs_ready);
    in_ready = !bus.flush && (state == IDLE || (state == HOLD && fire));
    capture  = bus.in_valid && in_ready;
  end

  // Entry register, FSM and counters; flush beats capture, capture beats the fire-to-IDLE drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      instr_q    <= '0;
      pc_q       <= '0;
      illegal_q  <= 1'b0;
      disp_cnt_q <= '0;
      stall_q    <= '0;
    end else begin
      if (capture) begin
        instr_q <= bus.in_instr;
        pc_q    <= bus.in_pc;
      end
      if (bus.flush) begin
        state     <= IDLE;
        illegal_q <= 1'b0;
      end else if (capture) begin
        if (fu_class(bus.in_instr[6:0]) != 3'b000) begin
          state     <= HOLD;
          illegal_q <= 1'b0;
        end else begin
          state     <= EXC;
          illegal_q <= 1'b1;
        end
      end else if (fire) begin
        state     <= IDLE;
        illegal_q <= 1'b0;
      end
      if (fire) begin
        disp_cnt_q <= disp_cnt_q + 32'd1;
      end
      if (state == HOLD && !fire && !bus.flush && stall_q != {STALL_W{1'b1}}) begin
        stall_q <= stall_q + STALL_W'(1);
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.disp_valid = disp_valid;
  assign bus.disp_instr = instr_q;
  assign bus.disp_pc    = pc_q;
  assign bus.rob_alloc  = fire;
  assign bus.fl_pop     = fire && need_preg;
  assign bus.illegal    = illegal_q;
  assign bus.disp_cnt   = disp_cnt_q;
  assign bus.stall_cnt  = stall_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Scoreboard bench for dispatch_scheduler: directed scenarios then constrained-random traffic.
// Latency: expectations are queued as each cycle's stimulus is applied and checked mid-cycle.
// Backpressure: all readies are randomized, including long stalls that saturate a narrow stall counter.
module tb_dispatch_scheduler;
  localparam int XLEN = 32;
  localparam int SW   = 4;

  typedef struct {
    bit          chk;
    bit          chk_regs;
    logic        in_ready;
    logic [2:0]  disp_valid;
    logic        rob_alloc;
    logic        fl_pop;
    logic        illegal;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] dcnt;
    logic [SW-1:0] scnt;
  } cyc_t;

  typedef struct {
    logic [2:0]  dv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fl_pop;
  } disp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dispatch_scheduler_if #(.XLEN(XLEN), .STALL_W(SW)) bus ();

  dispatch_scheduler #(.XLEN(XLEN), .STALL_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  cyc_t  cyc_q[$];
  disp_t disp_q[$];

  // Reference model: what the single entry holds, plus the two counters.
  bit          m_known = 0;
  bit          m_held  = 0;
  bit          m_fresh = 0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_dcnt  = '0;
  logic [SW-1:0] m_scnt = '0;
  logic [31:0] pc_ctr  = 32'h1000;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // 0 ALU, 1 branch, 2 LSU, 3 unsupported
  function automatic int unit_of(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h37, 7'h33: return 0;
      7'h63, 7'h67:        return 1;
      7'h03, 7'h23:        return 2;
      default:             return 3;
    endcase
  endfunction

  function automatic bit needs_reg(input logic [31:0] i);
    bit wr;
    wr = (i[6:0] == 7'h13) || (i[6:0] == 7'h37) || (i[6:0] == 7'h33) ||
         (i[6:0] == 7'h03) || (i[6:0] == 7'h67);
    return wr && (i[11:7] != 5'd0);
  endfunction

  // Apply one cycle of stimulus, queue what the DUT must show, then advance the model.
  task automatic step(input bit rst, input bit iv, input logic [31:0] ins, input bit fl,
                      input logic [2:0] rs, input bit rob, input bit flv);
    cyc_t  e;
    disp_t d;
    int    u;
    bit    legal_held, np, go, fire;
    logic [2:0] dv;
    @(negedge clk);
    rst_n         = !rst;
    bus.in_valid  = iv;
    bus.in_instr  = ins;
    bus.in_pc     = pc_ctr;
    bus.flush     = fl;
    bus.rs_ready  = rs;
    bus.rob_ready = rob;
    bus.fl_valid  = flv;

    u          = unit_of(m_instr);
    legal_held = m_held && (u != 3);
    np         = needs_reg(m_instr);
    go         = rob && (!np || flv);
    dv         = (legal_held && go && !fl) ? 3'(1 << u) : 3'b000;
    fire       = |(dv & rs);

    e.chk        = m_known;
    e.chk_regs   = m_held || m_fresh;
    e.in_ready   = !fl && (!m_held || fire);
    e.disp_valid = dv;
    e.rob_alloc  = fire;
    e.fl_pop     = fire && np;
    e.illegal    = m_held && (u == 3);
    e.instr      = m_instr;
    e.pc         = m_pc;
    e.dcnt       = m_dcnt;
    e.scnt       = m_scnt;
    cyc_q.push_back(e);
    if (fire && m_known) begin
      d.dv = dv; d.instr = m_instr; d.pc = m_pc; d.fl_pop = np;
      disp_q.push_back(d);
    end

    if (rst) begin
      m_known = 1; m_held = 0; m_fresh = 1;
      m_instr = '0; m_pc = '0; m_dcnt = '0; m_scnt = '0;
    end else begin
      if (legal_held && !fire && !fl && m_scnt != {SW{1'b1}}) m_scnt++;
      if (fire) m_dcnt++;
      if (fl) m_held = 0;
      else if (iv && e.in_ready) begin
        m_held = 1; m_fresh = 0; m_instr = ins; m_pc = pc_ctr;
      end else if (fire) m_held = 0;
    end
    pc_ctr += 4;
  endtask

  task automatic idle_cycles(input int n, input logic [2:0] rs);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, rs, 1, 1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] r;
    logic [4:0]  rd;
    ops = '{7'h13, 7'h37, 7'h33, 7'h63, 7'h67, 7'h03, 7'h23, 7'h7F, 7'h0F, 7'h73};
    r  = $urandom();
    rd = ($urandom_range(0, 3) == 0) ? 5'd0 : r[11:7];
    return {r[31:12], rd, ops[$urandom_range(0, 9)]};
  endfunction

  // Monitor: compares every checked cycle and pops the dispatch scoreboard on each DUT fire.
  initial begin
    cyc_t  e;
    disp_t d;
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() != 0) begin
        e = cyc_q.pop_front();
        if (e.chk) begin
          check("in_ready",   bus.in_ready,   e.in_ready);
          check("disp_valid", bus.disp_valid, e.disp_valid);
          check("rob_alloc",  bus.rob_alloc,  e.rob_alloc);
          check("fl_pop",     bus.fl_pop,     e.fl_pop);
          check("illegal",    bus.illegal,    e.illegal);
          check("disp_cnt",   bus.disp_cnt,   e.dcnt);
          check("stall_cnt",  bus.stall_cnt,  e.scnt);
          if (e.chk_regs) begin
            check("disp_instr", bus.disp_instr, e.instr);
            check("disp_pc",    bus.disp_pc,    e.pc);
          end
          if (|(bus.disp_valid & bus.rs_ready)) begin
            if (disp_q.size() == 0) begin
              check("unexpected_fire", 1, 0);
            end else begin
              d = disp_q.pop_front();
              check("fire_unit",   bus.disp_valid, d.dv);
              check("fire_instr",  bus.disp_instr, d.instr);
              check("fire_pc",     bus.disp_pc,    d.pc);
              check("fire_fl_pop", bus.fl_pop,     d.fl_pop);
            end
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.flush = 0;
    bus.rs_ready = 3'b111; bus.rob_ready = 1; bus.fl_valid = 1;

    // Reset; the second reset cycle is checked against reset values.
    step(1, 0, 32'h0, 0, 3'b111, 1, 1);
    step(1, 0, 32'h0, 0, 3'b111, 1, 1);

    // ADDI x1 with everything ready: dispatch next cycle with ROB and free-list pops.
    step(0, 1, 32'h00100093, 0, 3'b111, 1, 1);
    idle_cycles(1, 3'b111);

    // BNE stalled three cycles on the branch station, then released.
    step(0, 1, 32'h00209463, 0, 3'b111, 1, 1);
    idle_cycles(3, 3'b101);
    idle_cycles(2, 3'b111);

    // Back-to-back stream of four legal instructions.
    step(0, 1, 32'h00100093, 0, 3'b111, 1, 1);
    step(0, 1, 32'h002081b3, 0, 3'b111, 1, 1);
    step(0, 1, 32'h0000a203, 0, 3'b111, 1, 1);
    step(0, 1, 32'h0040a023, 0, 3'b111, 1, 1);
    idle_cycles(1, 3'b111);

    // ADDI x0 dispatches without a free register.
    step(0, 1, 32'h00000013, 0, 3'b111, 1, 0);
    step(0, 0, 32'h0, 0, 3'b111, 1, 0);

    // Unsupported opcode parks in the exception state until flushed.
    step(0, 1, 32'h0000007F, 0, 3'b111, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h00100093, 0, 3'b111, 1, 1);
    step(0, 0, 32'h0, 1, 3'b111, 1, 1);
    idle_cycles(1, 3'b111);

    // LW flushed in the cycle it would fire.
    step(0, 1, 32'h0000a283, 0, 3'b111, 1, 1);
    step(0, 1, 32'h00100093, 1, 3'b111, 1, 1);
    idle_cycles(1, 3'b111);

    // Long stall to saturate the stall counter, then reset mid-HOLD.
    step(0, 1, 32'h00100093, 0, 3'b111, 1, 1);
    idle_cycles(20, 3'b110);
    step(1, 0, 32'h0, 0, 3'b000, 1, 1);
    idle_cycles(2, 3'b111);

    // Constrained-random traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 9) < 7,
           rand_instr(),
           $urandom_range(0, 11) == 0,
           {$urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8},
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 8);
    end
    idle_cycles(2, 3'b111);

    @(negedge clk);
    #4;
    check("cycle_queue_drained", cyc_q.size(), 0);
    check("dispatch_queue_drained", disp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
